branch_predictor: RTL and testbench
===================================

Name: branch_predictor

Overview:
- Dynamic direction predictor for the 5-stage MIPS pipeline; the counterpart of the decode-stage branch comparator.
- In Fetch it predicts taken/not-taken for conditional branches from a table of 2-bit saturating counters.
- In Decode it receives the actual comparator outcome, trains the table and flags mispredictions so hazard/PC logic can redirect fetch.
- Also keeps branch and mispredict statistics counters.

Parameters:
- INDEX_BITS, 6, log2 of table entries (64 counters); index = pc[INDEX_BITS+1:2].
- CNT_INIT, 2'b01, reset value of every counter (weakly not-taken).

Ports:
- clk  input  1  clock, all state updates on rising edge.
- rst  input  1  synchronous reset, active-high.
- pcF  input  32  PC of instruction in Fetch.
- instrF  input  32  instruction word in Fetch.
- stallD  input  1  hold the F->D prediction register.
- flushD  input  1  clear the F->D prediction register.
- branchD  input  1  Decode holds a conditional branch; its resolution is valid.
- actual_takeD  input  1  branch outcome from the comparator.
- pred_takeF  output  1  predict-taken for the Fetch instruction (combinational).
- pred_takeD  output  1  registered prediction travelling with the Decode instruction.
- mispredictD  output  1  branchD & (pred_takeD != actual_takeD) (combinational).
- branch_cnt  output  32  resolved branches since reset.
- miss_cnt  output  32  mispredictions since reset.

Behaviour:
- Predecode in Fetch. is_branchF = 1 for:
  - op 000100 BEQ, 000101 BNE, 000110 BLEZ, 000111 BGTZ;
  - op 000001 REGIMM with rt in {00000 BLTZ, 00001 BGEZ, 10000 BLTZAL, 10001 BGEZAL}.
  - All other encodings give is_branchF = 0.
- pred_takeF = is_branchF & table[idxF][1]; idxF = pcF[INDEX_BITS+1:2]. Zero added latency.
- F->D register holds pred_takeD, idxD and is_branchD.
  - rst or flushD: all cleared to 0 (flushD has priority over stallD).
  - stallD: hold.
  - Otherwise load pred_takeF, idxF, is_branchF.
- Training: when branchD & ~stallD & ~rst, table[idxD] updates at the clock edge.
  - actual_takeD = 1: increment, saturating at 11.
  - actual_takeD = 0: decrement, saturating at 00.
- No update while stallD = 1, so a stalled branch trains exactly once.
- Read/write collision: if Fetch reads the index being written in the same cycle, pred_takeF uses the pre-update value. No bypass.
- mispredictD is combinational and valid whenever branchD = 1; it is 0 when branchD = 0.
  - pred_takeD is gated by is_branchD, so a non-branch never predicts taken.
- Statistics: on each training event, branch_cnt += 1, and miss_cnt += 1 if mispredictD.
  - Both counters saturate at 32'hFFFF_FFFF and never wrap.
- Reset values:
  - every table entry = CNT_INIT;
  - pred_takeD = 0, branch_cnt = 0, miss_cnt = 0;
  - pred_takeF = 0 until a counter reaches 1x.
- Reset takes effect on the next edge even mid-operation; a training event in the reset cycle is discarded.
- Table clear is a synchronous all-entry write.

Test Plan:
- Reset, then present BEQ at pcF=0x00400010 -> pred_takeF=0; branch_cnt=0, miss_cnt=0; all 64 entries read 01.
- Same BEQ resolved taken twice (branchD=1, actual_takeD=1, no stall) -> counter 01->10->11; next fetch of 0x00400010 gives pred_takeF=1; branch_cnt=2, miss_cnt=2.
- Counter at 11, resolve not-taken once -> 10, pred_takeF still 1; three more not-taken -> 01, 00, 00 (saturates); pred_takeF=0.
- ADDU instr at a PC whose entry is 11 -> pred_takeF=0. REGIMM with rt=00010 -> pred_takeF=0. BGEZAL (rt=10001) -> pred_takeF=1.
- stallD=1 for 3 cycles with branchD=1 -> entry updates once (after stall release); branch_cnt+=1.
- flushD=1 with stallD=1 -> pred_takeD=0 next cycle.
- Fetch and train index 5 in the same cycle (entry 01, taken) -> pred_takeF=0 this cycle, 1 the following cycle.
- Preload miss_cnt near saturation (force 32'hFFFF_FFFE), two mispredicts -> ends at 32'hFFFF_FFFF.
- Assert rst during a training cycle -> entry stays 01 and counters are 0.

Source files
------------

// File: rtl/branch_predictor.sv
// Dynamic branch direction predictor for the 5-stage MIPS pipeline.
// Fetch: predecode the instruction and look up a 2-bit saturating counter.
// Decode: train the counter with the comparator outcome, flag mispredicts
// and keep saturating branch / mispredict statistics.
module branch_predictor #(
  parameter int         INDEX_BITS = 6,
  parameter logic [1:0] CNT_INIT   = 2'b01
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] pcF,
  input  logic [31:0] instrF,
  input  logic        stallD,
  input  logic        flushD,
  input  logic        branchD,
  input  logic        actual_takeD,
  output logic        pred_takeF,
  output logic        pred_takeD,
  output logic        mispredictD,
  output logic [31:0] branch_cnt,
  output logic [31:0] miss_cnt
);

  localparam int ENTRIES = 1 << INDEX_BITS;

  typedef enum logic [5:0] {
    OP_REGIMM = 6'b000001,
    OP_BEQ    = 6'b000100,
    OP_BNE    = 6'b000101,
    OP_BLEZ   = 6'b000110,
    OP_BGTZ   = 6'b000111
  } opcode_e;

  logic [1:0]            r_table [ENTRIES];
  logic                  r_pred_takeD;
  logic                  r_is_branchD;
  logic [INDEX_BITS-1:0] r_idxD;
  logic [31:0]           r_branch_cnt;
  logic [31:0]           r_miss_cnt;

  logic [INDEX_BITS-1:0] w_idxF;
  logic [5:0]            w_op;
  logic [4:0]            w_rt;
  logic                  w_is_branchF;
  logic                  w_train;
  logic                  w_unused;

  assign w_idxF = pcF[INDEX_BITS+1:2];
  assign w_op   = instrF[31:26];
  assign w_rt   = instrF[20:16];

  // PC byte offset, upper PC bits and non-opcode instruction fields play no part in prediction.
  assign w_unused = ^{pcF[31:INDEX_BITS+2], pcF[1:0], instrF[25:21], instrF[15:0]};

  // Predecode: recognise conditional branches (REGIMM only for the four branch rt codes).
  always_comb begin
    // NOTE: default first so every path assigns the output and no latch is inferred.
    w_is_branchF = 1'b0;
    case (w_op)
      OP_BEQ, OP_BNE, OP_BLEZ, OP_BGTZ: w_is_branchF = 1'b1;
      OP_REGIMM: w_is_branchF = (w_rt == 5'b00000) || (w_rt == 5'b00001) ||
                                (w_rt == 5'b10000) || (w_rt == 5'b10001);
      default:   w_is_branchF = 1'b0;
    endcase
  end

  // Read the counter before any same-cycle update lands: no write-to-read bypass.
  assign pred_takeF = w_is_branchF & r_table[w_idxF][1];

  // A stalled branch trains only once it leaves Decode; reset is handled by priority below.
  assign w_train = branchD & ~stallD;

  assign pred_takeD  = r_pred_takeD & r_is_branchD;
  assign mispredictD = branchD & (pred_takeD != actual_takeD);
  assign branch_cnt  = r_branch_cnt;
  assign miss_cnt    = r_miss_cnt;

  // F->D prediction register: flush beats stall, stall holds, otherwise follow Fetch.
  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments for all clocked state so every register samples pre-edge values.
    if (rst || flushD) begin
      r_pred_takeD <= 1'b0;
      r_is_branchD <= 1'b0;
      r_idxD       <= '0;
    end else if (!stallD) begin
      r_pred_takeD <= pred_takeF;
      r_is_branchD <= w_is_branchF;
      r_idxD       <= w_idxF;
    end
  end

  // Counter table: synchronous clear of all entries, else saturating train on resolution.
  always_ff @(posedge clk) begin
    // NOTE: the table is deliberately reset entry-by-entry so every branch starts weakly not-taken.
    if (rst) begin
      for (int i = 0; i < ENTRIES; i++) r_table[i] <= CNT_INIT;
    end else if (w_train) begin
      if (actual_takeD) begin
        if (r_table[r_idxD] != 2'b11) r_table[r_idxD] <= r_table[r_idxD] + 2'd1;
      end else begin
        if (r_table[r_idxD] != 2'b00) r_table[r_idxD] <= r_table[r_idxD] - 2'd1;
      end
    end
  end

  // Statistics counters, saturating at all-ones.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_branch_cnt <= '0;
      r_miss_cnt   <= '0;
    end else if (w_train) begin
      if (r_branch_cnt != 32'hFFFF_FFFF) r_branch_cnt <= r_branch_cnt + 32'd1;
      if (mispredictD && (r_miss_cnt != 32'hFFFF_FFFF)) r_miss_cnt <= r_miss_cnt + 32'd1;
    end
  end

endmodule

// File: tb/tb_branch_predictor.sv
// Directed testbench for branch_predictor: reset state, training and
// saturation, predecode, stall/flush handling, read/write collision,
// statistics saturation and reset during a training cycle.
module tb_branch_predictor;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] pcF;
  logic [31:0] instrF;
  logic        stallD;
  logic        flushD;
  logic        branchD;
  logic        actual_takeD;
  logic        pred_takeF;
  logic        pred_takeD;
  logic        mispredictD;
  logic [31:0] branch_cnt;
  logic [31:0] miss_cnt;

  int tests  = 0;
  int failed = 0;

  localparam logic [31:0] PC_IDX4   = 32'h0040_0010;
  localparam logic [31:0] PC_IDX5   = 32'h0040_0014;
  localparam logic [31:0] I_BEQ     = 32'h1085_0003;
  localparam logic [31:0] I_ADDU    = 32'h0085_1021;
  localparam logic [31:0] I_REGIMM2 = 32'h0482_0005;
  localparam logic [31:0] I_BGEZAL  = 32'h0491_0005;
  localparam logic [31:0] I_BLTZ    = 32'h0480_0005;
  localparam logic [31:0] I_BGTZ    = 32'h1C80_0005;

  branch_predictor dut (
    .clk          (clk),
    .rst          (rst),
    .pcF          (pcF),
    .instrF       (instrF),
    .stallD       (stallD),
    .flushD       (flushD),
    .branchD      (branchD),
    .actual_takeD (actual_takeD),
    .pred_takeF   (pred_takeF),
    .pred_takeD   (pred_takeD),
    .mispredictD  (mispredictD),
    .branch_cnt   (branch_cnt),
    .miss_cnt     (miss_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    tests++;
    assert (observed === expected)
    else begin
      failed++;
      $error("FAIL %s: observed %h expected %h", tag, observed, expected);
    end
  endtask

  // Advance one rising edge and sample 1 time unit later.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst = 1'b1; pcF = PC_IDX4; instrF = I_BEQ;
    stallD = 1'b0; flushD = 1'b0; branchD = 1'b0; actual_takeD = 1'b0;
    tick(); tick();
    rst = 1'b0;
    #1;

    // Reset state
    check("rst_pred_takeF", {31'd0, pred_takeF}, 32'd0);
    check("rst_pred_takeD", {31'd0, pred_takeD}, 32'd0);
    check("rst_branch_cnt", branch_cnt, 32'd0);
    check("rst_miss_cnt", miss_cnt, 32'd0);
    for (int i = 0; i < 64; i++) check($sformatf("rst_entry%0d", i), {30'd0, dut.r_table[i]}, 32'd1);

    // BEQ moves into Decode with a not-taken prediction; resolve taken twice
    tick();
    branchD = 1'b1; actual_takeD = 1'b1;
    #1;
    check("taken1_mispredict", {31'd0, mispredictD}, 32'd1);
    tick();
    check("taken1_entry", {30'd0, dut.r_table[4]}, 32'd2);
    check("taken1_predF", {31'd0, pred_takeF}, 32'd1);
    tick();
    branchD = 1'b0;
    #1;
    check("taken2_entry", {30'd0, dut.r_table[4]}, 32'd3);
    check("taken2_predF", {31'd0, pred_takeF}, 32'd1);
    check("taken2_predD", {31'd0, pred_takeD}, 32'd1);
    check("taken2_branch_cnt", branch_cnt, 32'd2);
    check("taken2_miss_cnt", miss_cnt, 32'd2);
    check("nobranch_mispredict", {31'd0, mispredictD}, 32'd0);

    // Predecode with entry 4 at 11
    instrF = I_ADDU;    #1; check("addu_predF", {31'd0, pred_takeF}, 32'd0);
    instrF = I_REGIMM2; #1; check("regimm_rt2_predF", {31'd0, pred_takeF}, 32'd0);
    instrF = I_BGEZAL;  #1; check("bgezal_predF", {31'd0, pred_takeF}, 32'd1);
    instrF = I_BLTZ;    #1; check("bltz_predF", {31'd0, pred_takeF}, 32'd1);
    instrF = I_BGTZ;    #1; check("bgtz_predF", {31'd0, pred_takeF}, 32'd1);
    instrF = I_BEQ;     #1;

    // Not-taken once: 11 -> 10, still predicts taken
    branchD = 1'b1; actual_takeD = 1'b0;
    #1;
    check("nt1_mispredict", {31'd0, mispredictD}, 32'd1);
    tick();
    check("nt1_entry", {30'd0, dut.r_table[4]}, 32'd2);
    check("nt1_predF", {31'd0, pred_takeF}, 32'd1);
    check("nt1_branch_cnt", branch_cnt, 32'd3);
    // Three more: 01, 00, 00 (last one predicted not-taken, so no miss)
    tick(); tick(); tick();
    branchD = 1'b0;
    #1;
    check("nt4_entry", {30'd0, dut.r_table[4]}, 32'd0);
    check("nt4_predF", {31'd0, pred_takeF}, 32'd0);
    check("nt4_branch_cnt", branch_cnt, 32'd6);
    check("nt4_miss_cnt", miss_cnt, 32'd5);

    // Stall three cycles with a resolved branch: no training until release
    stallD = 1'b1; branchD = 1'b1; actual_takeD = 1'b1;
    tick(); tick(); tick();
    check("stall_entry", {30'd0, dut.r_table[4]}, 32'd0);
    check("stall_branch_cnt", branch_cnt, 32'd6);
    stallD = 1'b0;
    tick();
    check("release_entry", {30'd0, dut.r_table[4]}, 32'd1);
    check("release_branch_cnt", branch_cnt, 32'd7);
    check("release_miss_cnt", miss_cnt, 32'd6);

    // Train to 10 so Decode carries a taken prediction, then flush during stall
    tick();
    branchD = 1'b0;
    tick();
    check("preflush_predD", {31'd0, pred_takeD}, 32'd1);
    flushD = 1'b1; stallD = 1'b1;
    tick();
    check("flush_predD", {31'd0, pred_takeD}, 32'd0);
    flushD = 1'b0; stallD = 1'b0;

    // Same-cycle fetch and train of index 5: pre-update value is seen
    pcF = PC_IDX5;
    tick();
    branchD = 1'b1; actual_takeD = 1'b1;
    #1;
    check("collide_predF_same", {31'd0, pred_takeF}, 32'd0);
    tick();
    branchD = 1'b0;
    #1;
    check("collide_predF_next", {31'd0, pred_takeF}, 32'd1);
    check("collide_branch_cnt", branch_cnt, 32'd9);
    check("collide_miss_cnt", miss_cnt, 32'd8);

    // miss_cnt saturation: preload near the top, then two mispredicts
    dut.r_miss_cnt = 32'hFFFF_FFFE;
    branchD = 1'b1; actual_takeD = 1'b1;
    #1;
    check("sat1_mispredict", {31'd0, mispredictD}, 32'd1);
    tick();
    check("sat1_miss_cnt", miss_cnt, 32'hFFFF_FFFF);
    actual_takeD = 1'b0;
    #1;
    check("sat2_mispredict", {31'd0, mispredictD}, 32'd1);
    tick();
    branchD = 1'b0;
    #1;
    check("sat2_miss_cnt", miss_cnt, 32'hFFFF_FFFF);
    check("sat2_branch_cnt", branch_cnt, 32'd11);
    check("sat2_entry", {30'd0, dut.r_table[5]}, 32'd2);

    // Reset during a training cycle: the training is discarded
    rst = 1'b1; branchD = 1'b1; actual_takeD = 1'b1;
    tick();
    rst = 1'b0; branchD = 1'b0;
    #1;
    check("rsttrain_entry5", {30'd0, dut.r_table[5]}, 32'd1);
    check("rsttrain_entry4", {30'd0, dut.r_table[4]}, 32'd1);
    check("rsttrain_branch_cnt", branch_cnt, 32'd0);
    check("rsttrain_miss_cnt", miss_cnt, 32'd0);
    check("rsttrain_predD", {31'd0, pred_takeD}, 32'd0);
    check("rsttrain_predF", {31'd0, pred_takeF}, 32'd0);

    tick();
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
